memory_tank_seq: RTL

Serial access sequencer for one EDSAC mercury delay-line tank. It owns the digit and minor-cycle timing for the tank and accepts word-level read/write requests. It serialises write data into the tank input, deserialises the tank output on reads, and drives the tank's clear/in/out gates. It sits between the store address/transfer logic and a single tank instance, one sequencer per tank.

---
 rtl/edsac_mem_pkg.sv | 20 ++
 rtl/memory_digit_timer.sv | 35 +++
 rtl/memory_tank_seq.sv | 124 ++++++++++++
 3 files changed

// File: rtl/edsac_mem_pkg.sv
// Shared definitions for the EDSAC mercury-tank store: digit timing constants,
// default geometry, word/slot types and the tank sequencer state encoding.
package edsac_mem_pkg;

  localparam int DIGITS_PER_MC = 18;
  localparam int DEF_WORD_BITS = 17;
  localparam int DEF_GAP_BITS  = 1;
  localparam int DEF_SLOTS     = 32;

  typedef logic [DEF_WORD_BITS-1:0]     word_t;
  typedef logic [$clog2(DEF_SLOTS)-1:0] slot_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_XFER = 2'd2,
    ST_DONE = 2'd3
  } mem_state_e;

endpackage

// File: rtl/memory_digit_timer.sv
// Free-running digit / minor-cycle counter pair for one tank; dig_wrap is high
// in the last digit of every minor cycle.
module memory_digit_timer
  import edsac_mem_pkg::*;
#(
  parameter int DIGITS = DIGITS_PER_MC,
  parameter int SLOTS  = DEF_SLOTS
) (
  input  logic                      clk,
  input  logic                      rst_n,
  output logic [$clog2(DIGITS)-1:0] dig_cnt,
  output logic [$clog2(SLOTS)-1:0]  mc_cnt,
  output logic                      dig_wrap
);

  localparam int DW = $clog2(DIGITS);
  localparam int SW = $clog2(SLOTS);
  localparam logic [DW-1:0] DIG_LAST = DW'(DIGITS - 1);
  localparam logic [SW-1:0] MC_LAST  = SW'(SLOTS - 1);

  assign dig_wrap = (dig_cnt == DIG_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_cnt <= '0;
      mc_cnt  <= '0;
    end else if (dig_wrap) begin
      dig_cnt <= '0;
      mc_cnt  <= (mc_cnt == MC_LAST) ? '0 : mc_cnt + 1'b1;
    end else begin
      dig_cnt <= dig_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/memory_tank_seq.sv
// Word-level read/write sequencer for one mercury delay-line tank.
// Optional MEMORY_TANK_MONITOR_EN adds the registered CRT monitor stream.
module memory_tank_seq
  import edsac_mem_pkg::*;
#(
  parameter int WORD_BITS = DEF_WORD_BITS,
  parameter int GAP_BITS  = DEF_GAP_BITS,
  parameter int SLOTS     = DEF_SLOTS
) (
  input  logic                                   r2_clk,
  input  logic                                   r2_rst_n,
  // Request handshake: a request transfers on any clock where req_valid and
  // req_ready are both high; req_ready is high exactly while the FSM is idle.
  input  logic                                   req_valid,
  output logic                                   req_ready,
  input  logic                                   req_write,
  input  logic [$clog2(SLOTS)-1:0]               req_slot,
  input  logic [WORD_BITS-1:0]                   req_data,
  output logic                                   rsp_valid,
  output logic [WORD_BITS-1:0]                   rsp_data,
  input  logic                                   tank_mob,
  output logic                                   tank_mib,
  output logic                                   tank_clr,
  output logic                                   tank_in,
  output logic                                   tank_out,
  output logic [$clog2(WORD_BITS+GAP_BITS)-1:0]  dig_cnt,
  output logic [$clog2(SLOTS)-1:0]               mc_cnt,
  output logic                                   monitor,
  output mem_state_e                             state_dbg
);

  localparam int DIGITS = WORD_BITS + GAP_BITS;
  localparam int DW     = $clog2(DIGITS);
  localparam int SW     = $clog2(SLOTS);
  localparam logic [DW-1:0] LAST_DATA_DIG = DW'(WORD_BITS - 1);
  localparam logic [SW-1:0] LAST_SLOT     = SW'(SLOTS - 1);

  mem_state_e           state, state_nxt;
  logic [SW-1:0]        slot_q;
  logic                 wr_q;
  logic [WORD_BITS-1:0] data_q, shift_q;
  logic                 dig_wrap;
  logic                 accept, wr_nxt, xfer_nxt;
  logic [WORD_BITS-1:0] data_nxt;
  logic [DW-1:0]        dig_nxt;

  memory_digit_timer #(.DIGITS(DIGITS), .SLOTS(SLOTS)) u_timer (
    .clk      (r2_clk),
    .rst_n    (r2_rst_n),
    .dig_cnt  (dig_cnt),
    .mc_cnt   (mc_cnt),
    .dig_wrap (dig_wrap)
  );

  function automatic logic [SW-1:0] prev_slot(input logic [SW-1:0] s);
    return (s == '0) ? LAST_SLOT : s - 1'b1;
  endfunction

  // Entering XFER is decided one cycle early (at the gap digit of the slot
  // before the target) so the registered gates line up with digit 0.
  always_comb begin
    accept    = req_valid && req_ready;
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept)
                 state_nxt = (dig_wrap && mc_cnt == prev_slot(req_slot)) ? ST_XFER : ST_WAIT;
      ST_WAIT: if (dig_wrap && mc_cnt == prev_slot(slot_q)) state_nxt = ST_XFER;
      ST_XFER: if (dig_cnt == LAST_DATA_DIG) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    wr_nxt   = accept ? req_write : wr_q;
    data_nxt = accept ? req_data  : data_q;
    xfer_nxt = (state_nxt == ST_XFER);
    dig_nxt  = (state == ST_XFER) ? dig_cnt + 1'b1 : '0;
  end

  always_ff @(posedge r2_clk or negedge r2_rst_n) begin
    if (!r2_rst_n) begin
      state     <= ST_IDLE;
      slot_q    <= '0;
      wr_q      <= 1'b0;
      data_q    <= '0;
      shift_q   <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      tank_clr  <= 1'b0;
      tank_in   <= 1'b0;
      tank_out  <= 1'b0;
      tank_mib  <= 1'b0;
    end else begin
      state     <= state_nxt;
      if (accept) begin
        slot_q <= req_slot;
        wr_q   <= req_write;
        data_q <= req_data;
      end
      req_ready <= (state_nxt == ST_IDLE);
      rsp_valid <= (state_nxt == ST_DONE);
      tank_clr  <= xfer_nxt && wr_nxt;
      tank_in   <= xfer_nxt && wr_nxt;
      tank_out  <= xfer_nxt && !wr_nxt;
      tank_mib  <= xfer_nxt && wr_nxt && data_nxt[dig_nxt];
      // LSB arrives first, so shifting right leaves digit 0 in bit 0 after 17 bits.
      if (state == ST_XFER && !wr_q) begin
        shift_q <= {tank_mob, shift_q[WORD_BITS-1:1]};
        if (state_nxt == ST_DONE) rsp_data <= {tank_mob, shift_q[WORD_BITS-1:1]};
      end
    end
  end

`ifdef MEMORY_TANK_MONITOR_EN
  always_ff @(posedge r2_clk or negedge r2_rst_n) begin
    if (!r2_rst_n) monitor <= 1'b0;
    else           monitor <= (state == ST_XFER && wr_q) ? tank_mib : tank_mob;
  end
`else
  assign monitor = 1'b0;
`endif

  assign state_dbg = state;

endmodule
